// File: rtl/rx_frame_pkg.sv
// Shared definitions for the rx frame dispatcher: FSM states, frame byte
// offsets, frame-control codes and the own-address helper.
package rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT,
    ST_HDR,
    ST_CHECK,
    ST_CMD,
    ST_DATA
  } state_t;

  // Byte offsets inside a received frame
  localparam int OFS_DA   = 0;
  localparam int OFS_FC   = 2;
  localparam int OFS_MODE = 3;
  localparam int OFS_ADDR = 4;
  localparam int OFS_CMD  = 7;

  // Frame-control codes and broadcast destination
  localparam logic [7:0] FC_CFG   = 8'h60;
  localparam logic [7:0] FC_RST   = 8'hFF;
  localparam logic [7:0] DA_BCAST = 8'hFF;

  // Width of the per-frame byte index (covers 7 header reads and up to 31+1024 payload bytes)
  localparam int IDX_W = 11;

  // Own bus address derived from the card position, 8-bit wrap
  function automatic logic [7:0] own_da(input logic [2:0] rack, input logic [3:0] slot);
    return 8'(rack) * 8'd14 + 8'd14 - 8'(slot);
  endfunction

endpackage

// File: rtl/rx_rd_pipe.sv
// Read-latency alignment pipe: carries {valid, byte index} alongside the rx
// buffer read so the returned byte arrives together with its tag.
module rx_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int IDX_W  = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_vld,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);

  logic [RD_LAT-1:0] r_vld_p;
  logic [IDX_W-1:0]  r_idx_p [RD_LAT];

  // Valid tags shift one stage per clock; cleared on reset so no stale write survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= i_vld;
      for (int i = 1; i < RD_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  // Byte indices follow the valid tags; qualified by valid, so no reset needed
  always_ff @(posedge clk) begin
    r_idx_p[0] <= i_idx;
    for (int i = 1; i < RD_LAT; i++) r_idx_p[i] <= r_idx_p[i-1];
  end

  assign o_vld = r_vld_p[RD_LAT-1];
  assign o_idx = r_idx_p[RD_LAT-1];

endmodule

// File: rtl/rx_frame_dispatch.sv
// Receive frame dispatcher: validates CRC, parses the header out of the link
// rx buffer and streams command/data payload into the channel chosen by MODE.
module rx_frame_dispatch
  import rx_frame_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int ADDR_W   = 24,
  parameter int BUF_AW   = 11,
  parameter int CMD_LEN  = 6,
  parameter int DATA_LEN = 128,
  parameter int RD_LAT   = 2,
  parameter int RST_CNT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ini_done,
  input  logic [2:0]        i_rack_id,
  input  logic [3:0]        i_slot_id,
  input  logic              i_rx_done,
  input  logic [1:0]        i_rx_crc_rslt,
  output logic              o_rx_buf_rden,
  output logic [BUF_AW-1:0] o_rx_buf_raddr,
  input  logic [7:0]        i_rx_buf_rdata,
  output logic [NUM_CH-1:0] o_dst_wren,
  output logic              o_dst_cmd,
  output logic [ADDR_W-1:0] o_dst_waddr,
  output logic [7:0]        o_dst_wdata,
  output logic              o_rx_flag,
  output logic [7:0]        o_rx_mode,
  output logic [ADDR_W-1:0] o_rx_addr,
  output logic              o_crc_err,
  output logic              o_frame_drop,
  output logic              o_overrun,
  output logic              o_card_reset,
  output logic              o_busy
);

  localparam int TOTAL = CMD_LEN + DATA_LEN;
  localparam int CNT_W = $clog2(RST_CNT + 1);

  state_t            r_state, w_nstate;
  logic              r_ini_s1, r_ini_s2, w_ini_rise;
  logic [7:0]        r_own_da;
  logic [IDX_W-1:0]  r_issue;
  logic              w_issue_en, w_busy, w_stream;
  logic              w_vld_p0;
  logic [IDX_W-1:0]  w_idx_p0;
  logic [7:0]        r_h_da, r_h_fc, r_h_mode;
  logic [23:0]       r_h_addr;
  logic [CNT_W-1:0]  r_ffcnt, w_ffcnt_nx;
  logic              w_crc_err, w_drop, w_overrun, w_card_rst, w_accept;
  logic              r_rx_flag, r_crc_err, r_frame_drop, r_overrun, r_card_reset;
  logic [7:0]        r_rx_mode;
  logic [ADDR_W-1:0] r_rx_addr;
  logic              w_console, w_is_cmd;
  logic [IDX_W-1:0]  w_kd;
  logic [ADDR_W-1:0] w_waddr;
  logic [NUM_CH-1:0] r_dst_wren_p1;
  logic              r_dst_cmd_p1;
  logic [ADDR_W-1:0] r_dst_waddr_p1;
  logic [7:0]        r_dst_wdata_p1;
  logic              w_unused;

  assign w_unused   = i_rx_crc_rslt[1];
  assign w_ini_rise = r_ini_s1 & ~r_ini_s2;
  assign w_busy     = (r_state == ST_HDR) || (r_state == ST_CHECK) || w_stream;
  assign w_stream   = (r_state == ST_CMD) || (r_state == ST_DATA);

  // Header reads 0..6, then payload reads starting at the command offset
  assign w_issue_en = ((r_state == ST_HDR) && (r_issue < IDX_W'(OFS_CMD))) ||
                      (w_stream && (r_issue < IDX_W'(TOTAL)));
  assign o_rx_buf_rden  = w_issue_en;
  assign o_rx_buf_raddr = !w_issue_en ? '0 :
                          (r_state == ST_HDR) ? BUF_AW'(r_issue) :
                                                BUF_AW'(r_issue + IDX_W'(OFS_CMD));

  // ---- stage p0: rx buffer data aligned with its byte index ----
  rx_rd_pipe #(.RD_LAT(RD_LAT), .IDX_W(IDX_W)) u_rd_pipe (
    .clk   (clk),
    .reset (reset),
    .i_vld (w_issue_en),
    .i_idx (r_issue),
    .o_vld (w_vld_p0),
    .o_idx (w_idx_p0)
  );

  // Payload destination address: console channels are ADDR-relative, others fixed
  assign w_console = r_rx_mode < 8'd2;
  assign w_is_cmd  = w_idx_p0 < IDX_W'(CMD_LEN);
  assign w_kd      = w_idx_p0 - IDX_W'(CMD_LEN);
  assign w_waddr   = w_is_cmd ?
                       (w_console ? (r_rx_addr >> 4) + ADDR_W'(w_idx_p0) : ADDR_W'(w_idx_p0)) :
                       (w_console ? r_rx_addr + ADDR_W'(w_kd) : ADDR_W'(8) + ADDR_W'(w_kd));

  // Next-state and event-pulse decode
  always_comb begin
    w_nstate   = r_state;
    w_crc_err  = 1'b0;
    w_drop     = 1'b0;
    w_overrun  = 1'b0;
    w_card_rst = 1'b0;
    w_accept   = 1'b0;
    w_ffcnt_nx = r_ffcnt;
    case (r_state)
      ST_OFF:  if (w_ini_rise) w_nstate = ST_WAIT;
      ST_WAIT: begin
        if (i_rx_done) begin
          if (!i_rx_crc_rslt[0]) w_crc_err = 1'b1;
          else                   w_nstate  = ST_HDR;
        end
      end
      ST_HDR:  if (w_vld_p0 && (w_idx_p0 == IDX_W'(OFS_ADDR + 2))) w_nstate = ST_CHECK;
      ST_CHECK: begin
        w_nstate = ST_WAIT;
        if ((r_h_da != r_own_da) && (r_h_da != DA_BCAST)) begin
          w_drop = 1'b1;
        end else if (r_h_fc == FC_RST) begin
          if (r_ffcnt == CNT_W'(RST_CNT - 1)) begin
            w_card_rst = 1'b1;
            w_ffcnt_nx = '0;
          end else begin
            w_ffcnt_nx = r_ffcnt + 1'b1;
          end
        end else if ((r_h_fc == FC_CFG) && (r_h_mode < 8'(NUM_CH))) begin
          w_ffcnt_nx = '0;
          w_accept   = 1'b1;
          w_nstate   = ST_CMD;
        end else begin
          w_drop     = 1'b1;
          w_ffcnt_nx = '0;
        end
      end
      ST_CMD:  if (w_vld_p0 && (w_idx_p0 == IDX_W'(CMD_LEN - 1))) w_nstate = ST_DATA;
      ST_DATA: if (w_vld_p0 && (w_idx_p0 == IDX_W'(TOTAL - 1)))   w_nstate = ST_WAIT;
      default: w_nstate = ST_OFF;
    endcase
    if (w_busy && i_rx_done) w_overrun = 1'b1;
  end

  // State, ini edge detect, counters and registered event outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_OFF;
      r_ini_s1     <= 1'b1;
      r_ini_s2     <= 1'b1;
      r_own_da     <= '0;
      r_ffcnt      <= '0;
      r_issue      <= '0;
      r_rx_flag    <= 1'b0;
      r_crc_err    <= 1'b0;
      r_frame_drop <= 1'b0;
      r_overrun    <= 1'b0;
      r_card_reset <= 1'b0;
      r_rx_mode    <= '0;
      r_rx_addr    <= '0;
    end else begin
      r_state      <= w_nstate;
      r_ini_s1     <= i_ini_done;
      r_ini_s2     <= r_ini_s1;
      r_ffcnt      <= w_ffcnt_nx;
      r_rx_flag    <= w_accept;
      r_crc_err    <= w_crc_err;
      r_frame_drop <= w_drop;
      r_overrun    <= w_overrun;
      r_card_reset <= w_card_rst;
      if ((r_state == ST_OFF) && w_ini_rise) r_own_da <= own_da(i_rack_id, i_slot_id);
      if (w_accept) begin
        r_rx_mode <= r_h_mode;
        r_rx_addr <= ADDR_W'(r_h_addr);
      end
      if (w_issue_en)                             r_issue <= r_issue + 1'b1;
      else if (!w_busy || (r_state == ST_CHECK)) r_issue <= '0;
    end
  end

  // Header byte capture as each header read returns
  always_ff @(posedge clk) begin
    if ((r_state == ST_HDR) && w_vld_p0) begin
      case (w_idx_p0)
        IDX_W'(OFS_DA):       r_h_da          <= i_rx_buf_rdata;
        IDX_W'(OFS_FC):       r_h_fc          <= i_rx_buf_rdata;
        IDX_W'(OFS_MODE):     r_h_mode        <= i_rx_buf_rdata;
        IDX_W'(OFS_ADDR):     r_h_addr[23:16] <= i_rx_buf_rdata;
        IDX_W'(OFS_ADDR + 1): r_h_addr[15:8]  <= i_rx_buf_rdata;
        IDX_W'(OFS_ADDR + 2): r_h_addr[7:0]   <= i_rx_buf_rdata;
        default: ;
      endcase
    end
  end

  // ---- stage p1: registered destination write, zero when idle ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dst_wren_p1  <= '0;
      r_dst_cmd_p1   <= 1'b0;
      r_dst_waddr_p1 <= '0;
      r_dst_wdata_p1 <= '0;
    end else begin
      r_dst_wren_p1  <= '0;
      r_dst_cmd_p1   <= 1'b0;
      r_dst_waddr_p1 <= '0;
      r_dst_wdata_p1 <= '0;
      if (w_stream && w_vld_p0) begin
        r_dst_wren_p1  <= NUM_CH'(1) << r_rx_mode;
        r_dst_cmd_p1   <= w_is_cmd;
        r_dst_waddr_p1 <= w_waddr;
        r_dst_wdata_p1 <= i_rx_buf_rdata;
      end
    end
  end

  assign o_dst_wren   = r_dst_wren_p1;
  assign o_dst_cmd    = r_dst_cmd_p1;
  assign o_dst_waddr  = r_dst_waddr_p1;
  assign o_dst_wdata  = r_dst_wdata_p1;
  assign o_rx_flag    = r_rx_flag;
  assign o_rx_mode    = r_rx_mode;
  assign o_rx_addr    = r_rx_addr;
  assign o_crc_err    = r_crc_err;
  assign o_frame_drop = r_frame_drop;
  assign o_overrun    = r_overrun;
  assign o_card_reset = r_card_reset;
  assign o_busy       = w_busy;

endmodule

// File: tb/tb_rx_frame_dispatch.sv
// Directed bench for rx_frame_dispatch. Three instances (RD_LAT = 1, 2, 3)
// share one rx buffer image and stimulus; index 1 (RD_LAT = 2) is the main DUT.
module tb_rx_frame_dispatch;

  localparam int NW = 6 + 128;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ini_done = 1'b0;
  logic       rx_done = 1'b0;
  logic [1:0] crc = 2'b00;
  logic [2:0] rack_id = '0;
  logic [3:0] slot_id = '0;
  logic [7:0] mem [2048];

  logic        rden  [3];
  logic [10:0] raddr [3];
  logic [7:0]  rdata [3];
  logic [2:0]  wren  [3];
  logic        dcmd  [3];
  logic [23:0] waddr [3];
  logic [7:0]  wdata [3];
  logic        flag  [3];
  logic [7:0]  rmode [3];
  logic [23:0] raddr_o [3];
  logic        crc_err [3];
  logic        drop  [3];
  logic        ovr   [3];
  logic        crst  [3];
  logic        busy  [3];

  logic [35:0] wq [3][$];
  int n_flag = 0, n_drop = 0, n_ovr = 0, n_crc = 0, n_crst = 0, n_rden = 0;
  int errors = 0, checks = 0;
  int snap [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rx_frame_dispatch #(
      .NUM_CH(3), .ADDR_W(24), .BUF_AW(11), .CMD_LEN(6), .DATA_LEN(128),
      .RD_LAT(g + 1), .RST_CNT(4)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .i_ini_done     (ini_done),
      .i_rack_id      (rack_id),
      .i_slot_id      (slot_id),
      .i_rx_done      (rx_done),
      .i_rx_crc_rslt  (crc),
      .o_rx_buf_rden  (rden[g]),
      .o_rx_buf_raddr (raddr[g]),
      .i_rx_buf_rdata (rdata[g]),
      .o_dst_wren     (wren[g]),
      .o_dst_cmd      (dcmd[g]),
      .o_dst_waddr    (waddr[g]),
      .o_dst_wdata    (wdata[g]),
      .o_rx_flag      (flag[g]),
      .o_rx_mode      (rmode[g]),
      .o_rx_addr      (raddr_o[g]),
      .o_crc_err      (crc_err[g]),
      .o_frame_drop   (drop[g]),
      .o_overrun      (ovr[g]),
      .o_card_reset   (crst[g]),
      .o_busy         (busy[g])
    );

    // Buffer with g+1 clocks of read latency
    logic [7:0] r_d [g + 1];
    always @(posedge clk) begin
      r_d[0] <= mem[raddr[g]];
      for (int i = 1; i < g + 1; i++) r_d[i] <= r_d[i-1];
    end
    assign rdata[g] = r_d[g];
  end

  // Write logs for every instance and event counters for the main one
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++)
      if (wren[g] != 3'b000) wq[g].push_back({wren[g], dcmd[g], waddr[g], wdata[g]});
    if (flag[1])    n_flag++;
    if (drop[1])    n_drop++;
    if (ovr[1])     n_ovr++;
    if (crc_err[1]) n_crc++;
    if (crst[1])    n_crst++;
    if (rden[1])    n_rden++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rx(input logic [1:0] c);
    rx_done = 1'b1;
    crc     = c;
    @(negedge clk);
    rx_done = 1'b0;
    crc     = 2'b00;
  endtask

  task automatic set_hdr(input logic [7:0] da, input logic [7:0] fc, input logic [7:0] mode,
                         input logic [23:0] addr);
    mem[0] = da;
    mem[1] = 8'h5A;
    mem[2] = fc;
    mem[3] = mode;
    mem[4] = addr[23:16];
    mem[5] = addr[15:8];
    mem[6] = addr[7:0];
  endtask

  task automatic take_snap();
    for (int g = 0; g < 3; g++) snap[g] = wq[g].size();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy[0] || busy[1] || busy[2]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 64'(n < 2000), 64'd1);
    tick(3);
  endtask

  // Expected i-th write of an accepted frame
  function automatic logic [35:0] exp_w(input int mode, input logic [23:0] addr, input int i);
    logic [23:0] a;
    logic [2:0]  en;
    en = 3'b001 << mode;
    if (i < 6) a = (mode < 2) ? (addr >> 4) + 24'(i) : 24'(i);
    else       a = (mode < 2) ? addr + 24'(i - 6) : 24'(8 + i - 6);
    return {en, (i < 6) ? 1'b1 : 1'b0, a, mem[7 + i]};
  endfunction

  task automatic check_frame(input string tag, input int mode, input logic [23:0] addr);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_nwr_lat%0d", tag, g + 1), 64'(wq[g].size() - snap[g]), 64'(NW));
      if (wq[g].size() - snap[g] >= NW)
        for (int i = 0; i < NW; i++)
          chk($sformatf("%s_wr%0d_lat%0d", tag, i, g + 1), 64'(wq[g][snap[g] + i]),
              64'(exp_w(mode, addr, i)));
    end
  endtask

  initial begin
    int s_flag, s_drop, s_ovr, s_crc, s_crst, s_rden, lat, n;
    logic found;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 13 + 5);

    // Reset state
    tick(3);
    chk("rst_busy",  64'(busy[1]), 64'd0);
    chk("rst_wren",  64'(wren[1]), 64'd0);
    chk("rst_rden",  64'(rden[1]), 64'd0);
    chk("rst_flag",  64'(flag[1]), 64'd0);
    chk("rst_waddr", 64'(waddr[1]), 64'd0);
    reset = 1'b0;
    tick(2);

    // rx_done before arming is ignored
    s_rden = n_rden; s_crc = n_crc;
    pulse_rx(2'b01);
    tick(5);
    chk("off_busy", 64'(busy[1]), 64'd0);
    chk("off_rden", 64'(n_rden - s_rden), 64'd0);
    chk("off_crc",  64'(n_crc - s_crc), 64'd0);

    // Arm: rack 1, slot 3 -> own address 25
    rack_id = 3'd1; slot_id = 4'd3; ini_done = 1'b1;
    tick(4);

    // Frame 1: console mode 0, ADDR 0x000120
    set_hdr(8'd25, 8'h60, 8'd0, 24'h000120);
    take_snap();
    s_flag = n_flag;
    rx_done = 1'b1; crc = 2'b01;
    lat = 0; found = 1'b0;
    while (!found && lat < 40) begin
      @(negedge clk);
      rx_done = 1'b0; crc = 2'b00;
      lat++;
      if (flag[1]) found = 1'b1;
    end
    chk("f1_latency", 64'(lat - 1), 64'd10);
    chk("f1_rx_mode", 64'(rmode[1]), 64'd0);
    chk("f1_rx_addr", 64'(raddr_o[1]), 64'h120);
    wait_idle("f1");
    chk("f1_flag_once", 64'(n_flag - s_flag), 64'd1);
    chk("f1_busy_low", 64'(busy[1]), 64'd0);
    check_frame("f1", 0, 24'h000120);

    // Frame 2: broadcast, mode 2, with rx_done arriving mid-DATA
    set_hdr(8'hFF, 8'h60, 8'd2, 24'hABCDEF);
    take_snap();
    s_flag = n_flag; s_ovr = n_ovr;
    pulse_rx(2'b01);
    tick(70);
    pulse_rx(2'b01);
    wait_idle("f2");
    chk("f2_overrun",  64'(n_ovr - s_ovr), 64'd1);
    chk("f2_flag_once", 64'(n_flag - s_flag), 64'd1);
    chk("f2_rx_mode",  64'(rmode[1]), 64'd2);
    chk("f2_rx_addr",  64'(raddr_o[1]), 64'hABCDEF);
    check_frame("f2", 2, 24'hABCDEF);

    // FC=FF counting: 3, then a config frame restarts the count, then 4
    s_crst = n_crst; s_drop = n_drop;
    set_hdr(8'd25, 8'hFF, 8'd0, 24'h0);
    repeat (3) begin pulse_rx(2'b01); wait_idle("ff_a"); end
    chk("ff_first3", 64'(n_crst - s_crst), 64'd0);
    set_hdr(8'd25, 8'h60, 8'd0, 24'h000040);
    pulse_rx(2'b01);
    wait_idle("ff_cfg");
    set_hdr(8'd25, 8'hFF, 8'd0, 24'h0);
    repeat (3) begin pulse_rx(2'b01); wait_idle("ff_b"); end
    chk("ff_after_restart3", 64'(n_crst - s_crst), 64'd0);
    pulse_rx(2'b01);
    wait_idle("ff_4th");
    chk("ff_card_reset", 64'(n_crst - s_crst), 64'd1);
    chk("ff_no_drop",    64'(n_drop - s_drop), 64'd0);

    // Bad CRC: error pulse, no buffer reads
    s_crc = n_crc; s_rden = n_rden;
    pulse_rx(2'b10);
    tick(10);
    chk("crc_err",  64'(n_crc - s_crc), 64'd1);
    chk("crc_rden", 64'(n_rden - s_rden), 64'd0);
    chk("crc_busy", 64'(busy[1]), 64'd0);

    // Foreign DA: dropped, no writes
    set_hdr(8'd24, 8'h60, 8'd0, 24'h000120);
    take_snap();
    s_drop = n_drop;
    pulse_rx(2'b01);
    wait_idle("da24");
    chk("da24_drop", 64'(n_drop - s_drop), 64'd1);
    chk("da24_nwr",  64'(wq[1].size() - snap[1]), 64'd0);

    // MODE beyond channel count: dropped
    set_hdr(8'd25, 8'h60, 8'd3, 24'h000120);
    take_snap();
    s_drop = n_drop;
    pulse_rx(2'b01);
    wait_idle("mode3");
    chk("mode3_drop", 64'(n_drop - s_drop), 64'd1);
    chk("mode3_nwr",  64'(wq[1].size() - snap[1]), 64'd0);

    // Reset while streaming the command region
    set_hdr(8'd25, 8'h60, 8'd1, 24'h000300);
    pulse_rx(2'b01);
    n = 0;
    while (wren[1] == 3'b000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_cmd", 64'(n < 100), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_wren",  64'(wren[1]), 64'd0);
    chk("mid_waddr", 64'(waddr[1]), 64'd0);
    chk("mid_busy",  64'(busy[1]), 64'd0);
    chk("mid_rden",  64'(rden[1]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    s_rden = n_rden; s_flag = n_flag;
    pulse_rx(2'b01);
    tick(20);
    chk("post_rst_busy", 64'(busy[1]), 64'd0);
    chk("post_rst_rden", 64'(n_rden - s_rden), 64'd0);
    chk("post_rst_flag", 64'(n_flag - s_flag), 64'd0);

    // Re-arm with a fresh ini_done rise and run a console mode 1 frame
    ini_done = 1'b0;
    tick(4);
    ini_done = 1'b1;
    tick(4);
    set_hdr(8'd25, 8'h60, 8'd1, 24'h000300);
    take_snap();
    s_flag = n_flag;
    pulse_rx(2'b01);
    wait_idle("f3");
    chk("f3_flag_once", 64'(n_flag - s_flag), 64'd1);
    chk("f3_rx_addr",   64'(raddr_o[1]), 64'h300);
    check_frame("f3", 1, 24'h000300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_dispatch.md
Name: rx_frame_dispatch

Overview:
- Parametrised successor of the backplane-bus receive controller.
- After the link layer signals a received frame, the block:
  - checks the CRC result;
  - parses the header (DA, SA, FC, MODE, ADDR) directly from the link rx buffer;
  - streams the command and data payloads into one of NUM_CH destination RAM channels selected by MODE.
- Sits between the link rx buffer and the local download/console RAMs, and feeds the tx path with mode/address.

Parameters:
- NUM_CH, 3, number of destination channels; a frame with MODE < NUM_CH is accepted (MODE 0/1 console, 2 download by default)
- ADDR_W, 24, destination address width
- BUF_AW, 11, rx buffer address width
- CMD_LEN, 6, command bytes per frame (1..31)
- DATA_LEN, 128, data bytes per frame (1..1024)
- RD_LAT, 2, rx buffer read latency in clocks (1..3)
- RST_CNT, 4, consecutive FC=FF frames that trigger card reset

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- ini_done  in  1  link init done; the rising edge arms the block
- rack_id  in  3  rack number, sampled on the ini_done rise
- slot_id  in  4  slot number, sampled on the ini_done rise
- rx_done  in  1  one-cycle pulse: frame in buffer
- rx_crc_rslt  in  2  bit0 = CRC good, valid with rx_done
- rx_buf_rden  out  1  buffer read enable
- rx_buf_raddr  out  BUF_AW  buffer read address
- rx_buf_rdata  in  8  buffer data, RD_LAT after rden
- dst_wren  out  NUM_CH  one-hot write enable
- dst_cmd  out  1  1 = command region, 0 = data region
- dst_waddr  out  ADDR_W  write address
- dst_wdata  out  8  write data
- rx_flag  out  1  one-cycle pulse: accepted frame header
- rx_mode  out  8  MODE, held until the next rx_flag
- rx_addr  out  ADDR_W  ADDR, held until the next rx_flag
- crc_err  out  1  one-cycle pulse
- frame_drop  out  1  one-cycle pulse: DA/FC/MODE reject
- overrun  out  1  one-cycle pulse: rx_done while busy
- card_reset  out  1  one-cycle pulse
- busy  out  1  frame processing in progress

Behaviour:
- Reset values: all outputs 0; state OFF; the FF counter is cleared.
- Frame layout in the rx buffer:
  - byte 0 DA
  - byte 1 SA (ignored)
  - byte 2 FC
  - byte 3 MODE
  - bytes 4..6 ADDR, MSB first, zero-extended/truncated to ADDR_W
  - bytes 7..7+CMD_LEN-1 command payload
  - the next DATA_LEN bytes are data payload
- Own address: own_da = rack*14 + 14 - slot, computed as 8-bit modulo.
- States:
  - OFF: wait for the ini_done rising edge (2-flop edge detect), latch rack/slot, go to WAIT.
  - WAIT: on rx_done:
    - if crc bit0 = 0: pulse crc_err, stay in WAIT;
    - otherwise go to HDR, busy = 1.
  - HDR: issue reads 0..6 on consecutive cycles; capture returned bytes at read cycle + RD_LAT; go to CHECK once byte 6 is captured.
  - CHECK (1 cycle):
    - DA not equal to own_da and not FF: drop.
    - FC = FF:
      - increment the FF counter;
      - if the counter reaches RST_CNT, pulse card_reset and clear the counter;
      - return to WAIT (no frame_drop).
    - FC = 60 and MODE < NUM_CH: clear the FF counter, pulse rx_flag, update rx_mode/rx_addr, go to CMD.
    - Any other FC or MODE: frame_drop, clear the FF counter, back to WAIT.
  - CMD:
    - stream CMD_LEN bytes with a pipelined read, one byte per cycle after RD_LAT fill;
    - dst_wren[MODE] = 1, dst_cmd = 1;
    - dst_waddr = (ADDR >> 4) + k for the console channels (MODE < 2), k for others;
    - after the last write, go to DATA with no idle cycle (reads of DATA overlap the CMD drain).
  - DATA:
    - stream DATA_LEN bytes, dst_cmd = 0;
    - dst_waddr = ADDR + k for console channels, 8 + k for others;
    - after the last write, go to WAIT, busy = 0.
- Address arithmetic wraps modulo 2^ADDR_W; the rx buffer address wraps modulo 2^BUF_AW.
- dst_wren, dst_waddr and dst_wdata change together and are registered; they are 0 when not writing.
- rx_buf_rden is high only on cycles issuing a read.
- A rx_done while busy is ignored and pulses overrun; the current frame completes.
- rx_done in OFF is ignored silently.
- If rx_done and the last DATA write occur in the same cycle, the frame is treated as overrun (busy is still 1).
- Latency: rx_done to rx_flag = 8 + RD_LAT clocks.
- Reset mid-frame: all writes stop immediately and the block returns to OFF, requiring a fresh ini_done rise.

Decomposition:
- Package rx_frame_pkg: state encoding, frame offsets (OFS_DA=0, OFS_FC=2, OFS_MODE=3, OFS_ADDR=4, OFS_CMD=7), FC codes (FC_CFG=8'h60, FC_RST=8'hFF), broadcast DA 8'hFF.
- Sub-module rx_rd_pipe:
  - an RD_LAT-deep shift register of {valid, byte index};
  - aligns rx_buf_rdata with its write address/region.

Test Plan:
- ini_done rise, rack=1, slot=3 (own_da=25); frame DA=25, FC=60, MODE=0, ADDR=0x000120, CRC ok -> rx_flag once, rx_addr=0x000120; 6 cmd writes to addr 0x12..0x17 with dst_wren=001, dst_cmd=1; then 128 data writes at 0x120..0x19F; busy drops after the last write.
- MODE=2, DA=FF -> dst_wren=100; cmd addr 0..5; data addr 8..135; payload bytes match buffer bytes 7..140 exactly.
- Four consecutive valid-CRC frames with FC=FF -> card_reset single pulse after the 4th only; a FC=60 frame in between restarts the count.
- crc bit0=0 -> crc_err pulse, no reads; DA=24 -> frame_drop, no writes; MODE=3 with NUM_CH=3 -> frame_drop.
- rx_done asserted mid-DATA -> overrun pulse, frame completes; RD_LAT=1 and 3 builds give identical write sequences.
- reset asserted during CMD -> outputs 0 next edge; the next rx_done is ignored until ini_done rises again.
